seq_priority_encoder: RTL and testbench
=======================================

// Module: seq_priority_encoder
// PURPOSE
//  Sequential N-to-log2(N) priority encoder; inverse companion to the 3-to-8 line decoder.
//  - Accepts a multi-hot request vector.
//  - Emits the index of every set bit, one per transfer, highest index first.
//  - Feeding each Code back through the line decoder reproduces the one-hot of that bit.
//  - Both sides use valid/ready handshakes, so it sits between a request source and a decoder/consumer.
// PARAMETERS
//  N  8  request vector width; power of 2, >= 2
//  W  3  code width = log2(N); must equal $clog2(N)
// PORTS
//  Clock      in   1  rising-edge clock; the only clock
//  Reset      in   1  synchronous, active-high reset
//  Enable     in   1  acceptance gate for new vectors; 0 blocks In_Ready
//  In_Valid   in   1  D is valid
//  In_Ready   out  1  block can accept D this cycle
//  D          in   N  request vector; bit i = request i
//  Out_Valid  out  1  Code is valid
//  Out_Ready  in   1  consumer takes Code this cycle
//  Code       out  W  binary index of the highest pending request
//  Last       out  1  with Out_Valid: this Code is the final one of the vector
//  Zero       out  1  one-cycle pulse, cycle after an all-zero vector is accepted
// BEHAVIOUR
//  Reset (sync, active-high):
//   - state=IDLE, pending=0, Out_Valid=0, Code=0, Last=0, Zero=0.
//   - In_Ready=0 during the Reset cycle.
//   - Reset overrides all other inputs, including mid-SCAN: pending is discarded and nothing more is emitted.
//  State IDLE:
//   - In_Ready = Enable & ~Reset (combinational). Out_Valid=0.
//   - Accept when In_Valid & In_Ready at a rising edge:
//     - D!=0: pending<=D, state<=SCAN.
//     - D==0: stay IDLE; Zero=1 for the next cycle only; no Code is emitted.
//  State SCAN:
//   - In_Ready=0. Out_Valid=1 from the cycle after accept (latency 1).
//   - Code = max i with pending[i]=1.
//   - Last = 1 iff pending has exactly one bit set.
//   - Code and Last are pure functions of the pending register: glitch-free and stable while stalled.
//   - Transfer = Out_Valid & Out_Ready at the edge: clear pending[Code].
//     - If Last: state<=IDLE, so In_Ready may rise in the very next cycle.
//   - Out_Ready=0 holds Code, Last and Out_Valid unchanged indefinitely.
//   - Enable has no effect in SCAN; an accepted vector always completes.
//   - In_Valid is ignored in SCAN and is not buffered.
//  Throughput:
//   - k set bits take k transfer cycles + 1 accept cycle.
//   - No back-to-back accept overlap: next accept is earliest the cycle after the Last transfer.
//  Ordering: strictly descending index; each set bit is emitted exactly once; no duplicates.
//  Width rules:
//   - Code zero-extended to W bits.
//   - Last is computed as "pending & (pending-1) == 0" on N bits.
// TESTING
//  - Reset, then D=8'b1010_0100 with In_Valid=1, Enable=1, Out_Ready=1 -> Code 7, 5, 2 on
//    consecutive cycles; Last only with 2; In_Ready=1 in the cycle after.
//  - D=8'b0000_0001 with Out_Ready=0 for 4 cycles, then 1 -> Code=0, Last=1 held stable all
//    4 cycles; one transfer; back to IDLE.
//  - D=8'h00 accepted -> Zero=1 for exactly one cycle; Out_Valid stays 0; In_Ready remains 1.
//  - Enable=0 with In_Valid=1, D=8'hFF -> In_Ready=0, nothing accepted.
//    Then Enable=1 -> Code 7..0, eight transfers, Last on Code 0.
//  - Reset asserted after the 2nd transfer of D=8'hFF -> next cycle Out_Valid=0, Code=0;
//    after Reset drops, In_Ready=1 and no stale codes appear.
//  - Loopback: every Code fed into Line_Decoder (Enable=1, {A,B,C}=Code) -> F equals the
//    one-hot of the emitted bit; the OR of all F values equals the original D.

Source files
------------

// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: sequential N-to-log2(N) priority encoder.
// Takes a multi-hot request vector and streams out the index of each set bit.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   enable_i     gates acceptance of new vectors (no effect while scanning)
//   in_valid_i   d_i is valid
//   in_ready_o   block can accept d_i this cycle
//   d_i          request vector, bit i = request i
//   out_valid_o  code_o / last_o are valid
//   out_ready_i  consumer takes code_o this cycle
//   code_o       index of the highest pending request
//   last_o       with out_valid_o: final code of the current vector
//   zero_o       one-cycle pulse after an all-zero vector is accepted
module seq_priority_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] d_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] code_o,
    output logic         last_o,
    output logic         zero_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_q, zero_d;

    logic [W-1:0] hi_idx;
    logic         one_left;
    logic         accept;
    logic         xfer;

    // Highest set bit of pending; ascending scan so the top index wins.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                hi_idx = W'(i);
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign one_left = (pending_q != '0) &&
                      ((pending_q & (pending_q - N'(1))) == '0);

    assign in_ready_o  = (state_q == IDLE) & enable_i & ~rst_i;
    assign accept      = in_valid_i & in_ready_o;
    assign out_valid_o = (state_q == SCAN);
    assign xfer        = out_valid_o & out_ready_i;

    // Outputs derive only from registered state, so they hold while stalled.
    assign code_o = hi_idx;
    assign last_o = out_valid_o & one_left;
    assign zero_o = zero_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (d_i != '0) begin
                        pending_d = d_i;
                        state_d   = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (xfer) begin
                    pending_d[hi_idx] = 1'b0;
                    if (one_left) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed self-checking bench for seq_priority_encoder.
// Codes are looped through a 3-to-8 line decoder model and OR-ed back.
module tb_seq_priority_encoder;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] code;
    logic       last;
    logic       zero;

    int checks   = 0;
    int failures = 0;
    logic [7:0] acc;

    seq_priority_encoder #(.N(8), .W(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .d_i         (d),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .code_o      (code),
        .last_o      (last),
        .zero_o      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] line_dec(input logic en,
                                            input logic [2:0] abc);
        logic [7:0] f;
        f = 8'h00;
        if (en) f[abc] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [2:0] c, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_code"}, 32'(code), 32'(c));
        chk({tag, "_last"}, 32'(last), 32'(l));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; in_valid = 1'b0;
        d = 8'h00; out_ready = 1'b0;
        tick();
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk_out("rst", 1'b0, 3'd0, 1'b0);
        chk("rst_zero", 32'(zero), 0);

        // Vector A4: 7, 5, 2 back to back
        rst = 1'b0; in_valid = 1'b1; d = 8'hA4; out_ready = 1'b1;
        #1;
        chk("a4_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        acc = 8'h00;
        chk_out("a4_c7", 1'b1, 3'd7, 1'b0);
        chk("a4_busy_ready", 32'(in_ready), 0);
        acc |= line_dec(1'b1, code);
        tick();
        chk_out("a4_c5", 1'b1, 3'd5, 1'b0);
        acc |= line_dec(1'b1, code);
        tick();
        chk_out("a4_c2", 1'b1, 3'd2, 1'b1);
        chk("a4_dec2", 32'(line_dec(1'b1, code)), 32'h04);
        acc |= line_dec(1'b1, code);
        tick();
        chk("a4_done_valid", 32'(out_valid), 0);
        chk("a4_done_ready", 32'(in_ready), 1);
        chk("a4_loopback", 32'(acc), 32'hA4);

        // Vector 01 with a 4-cycle stall
        in_valid = 1'b1; d = 8'h01; out_ready = 1'b0;
        tick();
        d = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            chk_out("stall", 1'b1, 3'd0, 1'b1);
            chk("stall_in_ready", 32'(in_ready), 0);
            if (i < 3) tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_done_valid", 32'(out_valid), 0);
        chk("stall_done_ready", 32'(in_ready), 1);

        // All-zero vector
        in_valid = 1'b1; d = 8'h00;
        tick();
        in_valid = 1'b0;
        chk("zero_pulse", 32'(zero), 1);
        chk("zero_valid", 32'(out_valid), 0);
        chk("zero_ready", 32'(in_ready), 1);
        tick();
        chk("zero_clear", 32'(zero), 0);
        chk("zero_valid2", 32'(out_valid), 0);

        // Enable gating, then FF
        enable = 1'b0; in_valid = 1'b1; d = 8'hFF;
        #1;
        chk("en0_ready", 32'(in_ready), 0);
        tick();
        chk("en0_valid", 32'(out_valid), 0);
        enable = 1'b1;
        #1;
        chk("en1_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        enable = 1'b0;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk_out("ff", 1'b1, 3'(7 - i), (i == 7));
            acc |= line_dec(1'b1, code);
            tick();
        end
        chk("ff_done_valid", 32'(out_valid), 0);
        chk("ff_loopback", 32'(acc), 32'hFF);
        enable = 1'b1;

        // Reset mid-scan after the 2nd transfer
        in_valid = 1'b1; d = 8'hFF;
        tick();
        in_valid = 1'b0;
        chk_out("mr_c7", 1'b1, 3'd7, 1'b0);
        tick();
        chk_out("mr_c6", 1'b1, 3'd6, 1'b0);
        tick();
        chk_out("mr_c5", 1'b1, 3'd5, 1'b0);
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        chk_out("mr_after", 1'b0, 3'd0, 1'b0);
        #1;
        chk("mr_ready", 32'(in_ready), 1);
        tick();
        chk_out("mr_quiet1", 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("mr_quiet2", 1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
